// File: rtl/card_shoe.sv
// card_shoe: multi-deck shoe dealing uniformly random cards as class pulses.
// Optional cut card behaviour enabled by defining SHOE_CUT_CARD_EN.
module card_shoe #(
    parameter int          MAX_DECKS = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  decks_in,
    input  logic        deal_req,
    output logic        small_add,
    output logic        seven_add,
    output logic        large_add,
    output logic [7:0]  decks,
    output logic [15:0] small_left,
    output logic [15:0] seven_left,
    output logic [15:0] large_left,
    output logic [15:0] remain,
    output logic        busy,
    output logic        empty,
    output logic        cut_reached
);

    typedef enum logic [1:0] {READY, PICK, EMIT} state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [15:0] rem_m1;
    logic [15:0] mask;
    logic [15:0] cand;
    logic [7:0]  d_clamp;
    logic [15:0] d_wide;
    logic        load_ok;
    logic        deal_ok;
    logic        accept;
    logic        take;

    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    assign remain = small_left + seven_left + large_left;
    assign empty  = (remain == 16'd0);
    assign busy   = (state != READY);

    // Smallest all-ones mask covering remain-1 keeps acceptance >= 50%.
    assign rem_m1 = remain - 16'd1;
    always_comb begin
        mask = rem_m1;
        mask = mask | (mask >> 1);
        mask = mask | (mask >> 2);
        mask = mask | (mask >> 4);
        mask = mask | (mask >> 8);
    end

    assign cand    = lfsr & mask;
    assign accept  = (cand < remain) && !empty;
    assign d_clamp = (decks_in > 8'(MAX_DECKS)) ? 8'(MAX_DECKS) : decks_in;
    assign d_wide  = {8'd0, d_clamp};
    assign load_ok = load && (decks_in != 8'd0);
    assign deal_ok = deal_req && !empty && !cut_reached;
    assign take    = !load_ok && (state == PICK) && accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= READY;
            lfsr       <= LFSR_SEED;
            decks      <= 8'd0;
            small_left <= 16'd0;
            seven_left <= 16'd0;
            large_left <= 16'd0;
            small_add  <= 1'b0;
            seven_add  <= 1'b0;
            large_add  <= 1'b0;
        end else begin
            lfsr      <= lfsr_next;
            small_add <= 1'b0;
            seven_add <= 1'b0;
            large_add <= 1'b0;
            if (load_ok) begin
                decks      <= d_clamp;
                small_left <= d_wide * 16'd24;
                seven_left <= d_wide * 16'd4;
                large_left <= d_wide * 16'd24;
                state      <= READY;
            end else begin
                unique case (state)
                    READY: if (deal_ok) state <= PICK;
                    PICK: begin
                        if (accept) begin
                            if (cand < small_left) begin
                                small_left <= small_left - 16'd1;
                                small_add  <= 1'b1;
                            end else if (cand < small_left + seven_left) begin
                                seven_left <= seven_left - 16'd1;
                                seven_add  <= 1'b1;
                            end else begin
                                large_left <= large_left - 16'd1;
                                large_add  <= 1'b1;
                            end
                            state <= EMIT;
                        end
                    end
                    EMIT:    state <= READY;
                    default: state <= READY;
                endcase
            end
        end
    end

`ifdef SHOE_CUT_CARD_EN
    logic [15:0] cut_thr;

    // Threshold is a quarter of the freshly loaded shoe (13 per deck).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cut_thr     <= 16'd0;
            cut_reached <= 1'b0;
        end else if (load_ok) begin
            cut_thr     <= (d_wide * 16'd52) >> 2;
            cut_reached <= 1'b0;
        end else if (take && (rem_m1 <= cut_thr)) begin
            cut_reached <= 1'b1;
        end
    end
`else
    assign cut_reached = 1'b0;
`endif

endmodule
